// File: rtl/comp_serial_2bit.sv
// comp_serial_2bit: multi-cycle unsigned magnitude comparator.
// Walks the latched operands two bits per cycle, MSB chunk first, and stops
// at the first unequal chunk. The result flags, chunk count, busy and done
// are all registered.
module comp_serial_2bit #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH / 2) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    chunks
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Chunk index of the final (least significant) 2-bit chunk
    localparam logic [CW-1:0] LAST_CHUNK = CW'(WIDTH / 2 - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic [CW-1:0]    chunks_q, chunks_d;

    // The chunk under test always sits in the top two bits of the shifters
    logic [1:0] chunk_a;
    logic [1:0] chunk_b;

    assign chunk_a = sa_q[WIDTH-1 -: 2];
    assign chunk_b = sb_q[WIDTH-1 -: 2];

    // Next-state and next-output logic; busy/done are derived from the next
    // state so that they are registered alongside it.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        chunks_d = chunks_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    chunks_d = '0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_COMPARE;
                end
            end

            S_COMPARE: begin
                chunks_d = chunks_q + CW'(1);
                if (chunk_a > chunk_b) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (chunk_a < chunk_b) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (chunks_q == LAST_CHUNK) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // Equal so far: bring the next chunk up to the top
                    sa_d    = sa_q << 2;
                    sb_d    = sb_q << 2;
                    busy_d  = 1'b1;
                end
            end

            S_DONE: begin
                // Any start seen here is dropped; it is re-sampled in IDLE
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            chunks_q <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            chunks_q <= chunks_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign gt     = gt_q;
    assign lt     = lt_q;
    assign eq     = eq_q;
    assign chunks = chunks_q;

endmodule

// File: tb/tb_comp_serial_2bit.sv
// Testbench for comp_serial_2bit: directed scenarios plus randomized
// operands, checked against an arithmetic reference model.
module tb_comp_serial_2bit;

    localparam int W  = 8;
    localparam int CW = $clog2(W / 2) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          gt;
    logic          lt;
    logic          eq;
    logic [CW-1:0] chunks;

    int n_cmp  = 0;
    int n_fail = 0;

    comp_serial_2bit #(.WIDTH(W), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .chunks (chunks)
    );

    always #5 clk = ~clk;

    // Hang guard
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: ordering from plain integer comparison; chunks examined is
    // the 2-bit chunk holding the most significant differing bit, or all of
    // them when the operands are equal.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic eg, output logic el, output logic ee,
                         output int ech);
        logic [W-1:0] x;
        int           msb;
        x   = av ^ bv;
        eg  = (av > bv);
        el  = (av < bv);
        ee  = (av == bv);
        msb = -1;
        for (int i = 0; i < W; i++)
            if (x[i]) msb = i;
        if (msb < 0) ech = W / 2;
        else         ech = (W - 1 - msb) / 2 + 1;
    endtask

    // One full compare: pulse start, scramble operands afterwards, wait for
    // done within a bound and check latency, busy time and result.
    task automatic do_compare(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic eg, el, ee;
        int   ech, cyc, busy_cnt;
        logic seen, flag_bad;
        model(av, bv, eg, el, ee, ech);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        cyc = 0; busy_cnt = 0; seen = 1'b0; flag_bad = 1'b0;
        for (int i = 0; i < W / 2 + 2 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cnt++;
                if (gt | lt | eq) flag_bad = 1'b1;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(cyc), 32'(ech + 1));
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(ech));
            check({tag, "_flags_inflight"}, 32'(flag_bad), 32'd0);
            check({tag, "_gt"}, 32'(gt), 32'(eg));
            check({tag, "_lt"}, 32'(lt), 32'(el));
            check({tag, "_eq"}, 32'(eq), 32'(ee));
            check({tag, "_chunks"}, 32'(chunks), 32'(ech));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int   ndone, last;
        logic [W-1:0] av, bv;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({gt, lt, eq}), 32'd0);
        check("rst_chunks", 32'(chunks), 32'd0);
        rst = 1'b0;

        // Early exit on first chunk, full-length equality, late differences
        do_compare(8'hA5, 8'h5A, "t1");
        do_compare(8'h3C, 8'h3C, "t2");
        do_compare(8'h30, 8'h31, "t3a");
        do_compare(8'h08, 8'h04, "t3b");

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h00; b = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("t4_busy", 32'(busy), 32'd1);
        a = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_done", 32'(done), 32'd1);
        check("t4_lt", 32'(lt), 32'd1);
        check("t4_chunks", 32'(chunks), 32'd1);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t4_no_second_done", 32'(ndone), 32'd0);
        check("t4_lt_held", 32'({gt, lt, eq}), 32'b010);

        // Reset mid-compare aborts without a done strobe
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h12;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_flags", 32'({gt, lt, eq}), 32'd0);
        check("t5_chunks", 32'(chunks), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("t5_no_activity", 32'(ndone), 32'd0);
        do_compare(8'h02, 8'h01, "t5b");

        // Randomized operands, biased towards long equal prefixes
        for (int n = 0; n < 40; n++) begin
            av = W'($urandom);
            case ($urandom_range(0, 2))
                0:       bv = W'($urandom);
                1:       bv = av ^ W'(1 << $urandom_range(0, W - 1));
                default: bv = av;
            endcase
            do_compare(av, bv, $sformatf("rnd%0d", n));
        end

        // start held high: one compare every three cycles
        @(negedge clk);
        start = 1'b1; a = 8'hC0; b = 8'h40;
        ndone = 0; last = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                if (ndone > 0) check("t6_gap", 32'(i - last), 32'd3);
                check("t6_gt", 32'({gt, lt, eq}), 32'b100);
                check("t6_chunks", 32'(chunks), 32'd1);
                ndone++;
                last = i;
            end
        end
        check("t6_done_count", 32'(ndone), 32'd4);
        start = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
